// File: rtl/bram_sdp_ctrl.sv
// bram_sdp_ctrl: round-robin arbiter sharing one simple-dual-port BRAM among NUM_REQ requesters,
// with a zero-fill sweep after reset so the memory never relies on initial contents.
module bram_sdp_ctrl #(
  parameter int NUM_REQ        = 4,
  parameter int ID_WIDTH       = 2,
  parameter int SIZE           = 512,
  parameter int ADDR_WIDTH     = 9,
  parameter int DATA_WIDTH     = 32,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                           clk,
  input  logic                           reset_n,
  input  logic [NUM_REQ-1:0]             req_valid,
  input  logic [NUM_REQ-1:0]             req_we,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]  req_addr,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]  req_wdata,
  output logic [NUM_REQ-1:0]             req_ready,
  output logic                           rsp_valid,
  output logic [ID_WIDTH-1:0]            rsp_id,
  output logic [DATA_WIDTH-1:0]          rsp_rdata,
  output logic                           init_done,
  output logic                           mem_ena,
  output logic                           mem_wea,
  output logic [ADDR_WIDTH-1:0]          mem_addra,
  output logic [DATA_WIDTH-1:0]          mem_dia,
  output logic                           mem_enb,
  output logic [ADDR_WIDTH-1:0]          mem_addrb,
  input  logic [DATA_WIDTH-1:0]          mem_dob
);
  localparam logic [ADDR_WIDTH-1:0] LAST = ADDR_WIDTH'(SIZE - 1);
  typedef enum logic {CLEAR, RUN} state_t;
  state_t state, state_nxt;
  logic [ADDR_WIDTH-1:0] clr_addr, g_addr;
  logic [DATA_WIDTH-1:0] g_data;
  logic [ID_WIDTH-1:0] rr_ptr, grant_id, cand;
  logic grant_any, g_we, in_range, clearing, run_go, rsp_oor;
  // Scan from the far end so the candidate closest to rr_ptr is written last and wins.
  always_comb begin
    grant_any = 1'b0;
    grant_id = '0;
    cand = '0;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      cand = ID_WIDTH'((int'(rr_ptr) + k) % NUM_REQ);
      if (req_valid[cand]) begin
        grant_any = 1'b1;
        grant_id = cand;
      end
    end
  end
  always_comb state_nxt = (state == CLEAR && clr_addr == LAST) ? RUN : state;
  assign g_addr    = req_addr[grant_id*ADDR_WIDTH +: ADDR_WIDTH];
  assign g_data    = req_wdata[grant_id*DATA_WIDTH +: DATA_WIDTH];
  assign g_we      = req_we[grant_id];
  assign in_range  = 32'(g_addr) < SIZE;
  assign clearing  = reset_n && state == CLEAR;
  assign run_go    = reset_n && state == RUN && grant_any;
  assign req_ready = run_go ? NUM_REQ'(1) << grant_id : '0;
  assign mem_ena   = clearing || (run_go && g_we && in_range);
  assign mem_wea   = mem_ena;
  assign mem_addra = clearing ? clr_addr : run_go ? g_addr : '0;
  assign mem_dia   = run_go ? g_data : '0;
  assign mem_enb   = run_go && !g_we && in_range;
  assign mem_addrb = run_go ? g_addr : '0;
  // Out-of-range reads never touch port B, so their response is forced to zero.
  assign rsp_rdata = rsp_oor ? '0 : mem_dob;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= (CLEAR_ON_RESET != 0) ? CLEAR : RUN;
      clr_addr  <= '0;
      rr_ptr    <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_oor   <= 1'b0;
      init_done <= CLEAR_ON_RESET == 0;
    end else begin
      state     <= state_nxt;
      clr_addr  <= (state == CLEAR) ? clr_addr + 1'b1 : clr_addr;
      rsp_valid <= run_go && !g_we;
      if (state == CLEAR && clr_addr == LAST) init_done <= 1'b1;
      if (run_go) rr_ptr <= (grant_id == ID_WIDTH'(NUM_REQ - 1)) ? '0 : grant_id + 1'b1;
      if (run_go && !g_we) begin
        rsp_id  <= grant_id;
        rsp_oor <= !in_range;
      end
    end
  end
endmodule
